// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requesters
module mem_port_arbiter #(
    parameter int AW  = 8,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       owner;       // 1 = data port, 0 = fetch port
    logic       last_grant;
    logic       grant;
    logic       grant_d;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant      = 1'b1;
                    // on a tie the port that did not win last time goes next
                    grant_d    = d_req && (!i_req || !last_grant);
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_next;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner      <= grant_d;
                        last_grant <= grant_d;
                        m_en       <= 1'b1;
                        m_we       <= grant_d & d_we;
                        m_addr     <= grant_d ? d_addr : i_addr;
                        cnt        <= CNT_INIT;
                        if (grant_d) begin
                            m_wdata <= d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        m_en <= 1'b0;
                        m_we <= 1'b0;
                        if (owner) begin
                            d_ack <= 1'b1;
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (LAT=2 and LAT=1 builds)
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [7:0]  i_addr, d_addr;
    logic [31:0] d_wdata;
    logic        i_ack, d_ack, m_en, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic [7:0]  m_addr;

    logic        b_d_req;
    logic [7:0]  b_d_addr;
    logic        b_i_ack, b_d_ack, b_m_en, b_m_we, b_busy;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_wdata, b_m_rdata;
    logic [7:0]  b_m_addr;

    logic [31:0] mem  [256];
    logic [31:0] mem1 [256];

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(8), .DW(32), .LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(8), .DW(32), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(1'b0), .i_addr(8'h00), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(1'b0), .d_addr(b_d_addr), .d_wdata(32'h0),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_rdata(b_m_rdata), .busy(b_busy)
    );

    assign m_rdata   = mem[m_addr];
    assign b_m_rdata = mem1[b_m_addr];

    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr] = m_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("ack_onehot", {63'b0, i_ack & d_ack}, 64'd0);
        if (i_ack || d_ack) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_unexpected_ack: observed i_ack=%0b d_ack=%0b expected no ack", i_ack, d_ack);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {63'b0, d_ack}, {63'b0, e.port});
                chk("ack_rdata", {32'b0, (e.port ? d_rdata : i_rdata)}, {32'b0, e.data});
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int       ack_cyc [4];
    logic     ack_prt [4];
    int       k;

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem[a]  = 32'h0;
            mem1[a] = 32'h0;
        end
        mem[8'h04]  = 32'h8C22_0000;
        mem[8'h20]  = 32'h1234_5678;
        mem1[8'h20] = 32'hCAFE_F00D;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        b_d_req = 0; b_d_addr = 0;
        do_reset();

        chk("rst_m_en", {63'b0, m_en}, 64'd0);
        chk("rst_m_addr", {56'b0, m_addr}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_i_rdata", {32'b0, i_rdata}, 64'd0);
        chk("rst_d_rdata", {32'b0, d_rdata}, 64'd0);

        // single fetch
        i_req = 1; i_addr = 8'h04; cyc = 0;
        sb.push_back('{port: 1'b0, data: 32'h8C22_0000});
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk("fetch_m_en", {63'b0, m_en}, 64'd1);
            chk("fetch_m_addr", {56'b0, m_addr}, 64'h04);
            chk("fetch_m_we", {63'b0, m_we}, 64'd0);
            chk("fetch_busy", {63'b0, busy}, 64'd1);
        end
        tick();
        chk("fetch_i_ack_c3", {63'b0, i_ack}, 64'd1);
        chk("fetch_busy_c3", {63'b0, busy}, 64'd1);
        i_req = 0;
        tick();
        chk("fetch_idle_c4", {63'b0, busy}, 64'd0);

        // store then load
        d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 32'hDEAD_BEEF; cyc = 0;
        sb.push_back('{port: 1'b1, data: 32'h0});
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk("store_m_we", {63'b0, m_we}, 64'd1);
            chk("store_m_wdata", {32'b0, m_wdata}, 64'hDEAD_BEEF);
        end
        tick();
        chk("store_d_ack_c3", {63'b0, d_ack}, 64'd1);
        d_req = 0; d_we = 0;
        tick();
        d_req = 1; cyc = 0;
        sb.push_back('{port: 1'b1, data: 32'hDEAD_BEEF});
        tick(); tick(); tick();
        chk("load_d_ack_c3", {63'b0, d_ack}, 64'd1);
        d_req = 0;
        tick();

        // simultaneous requests after reset: I, D, I
        do_reset();
        i_req = 1; i_addr = 8'h04; d_req = 1; d_we = 0; d_addr = 8'h10; cyc = 0; k = 0;
        sb.push_back('{port: 1'b0, data: 32'h8C22_0000});
        sb.push_back('{port: 1'b1, data: 32'hDEAD_BEEF});
        sb.push_back('{port: 1'b0, data: 32'h8C22_0000});
        for (int c = 1; c <= 11; c++) begin
            tick();
            if ((i_ack || d_ack) && k < 4) begin
                ack_cyc[k] = cyc;
                ack_prt[k] = d_ack;
                k++;
            end
        end
        i_req = 0; d_req = 0;
        tick();
        chk("rr_ack_count", 64'(k), 64'd3);
        chk("rr_ack0_cyc", 64'(ack_cyc[0]), 64'd3);
        chk("rr_ack1_cyc", 64'(ack_cyc[1]), 64'd7);
        chk("rr_ack2_cyc", 64'(ack_cyc[2]), 64'd11);
        chk("rr_ack0_port", {63'b0, ack_prt[0]}, 64'd0);
        chk("rr_ack1_port", {63'b0, ack_prt[1]}, 64'd1);
        chk("rr_ack2_port", {63'b0, ack_prt[2]}, 64'd0);
        tick();
        chk("rr_sb_drained", 64'(sb.size()), 64'd0);

        // request dropped during access still completes
        d_req = 1; d_we = 0; d_addr = 8'h20; cyc = 0;
        sb.push_back('{port: 1'b1, data: 32'h1234_5678});
        tick();
        d_req = 0; d_addr = 8'h10;
        tick(); tick();
        chk("drop_d_ack_c3", {63'b0, d_ack}, 64'd1);
        tick(); tick();
        chk("drop_no_restart", {63'b0, m_en}, 64'd0);

        // request held through ack: re-served from the following idle cycle
        d_req = 1; d_addr = 8'h20; cyc = 0;
        sb.push_back('{port: 1'b1, data: 32'h1234_5678});
        sb.push_back('{port: 1'b1, data: 32'h1234_5678});
        tick(); tick(); tick();
        chk("held_ack_c3", {63'b0, d_ack}, 64'd1);
        tick();
        chk("held_idle_c4", {63'b0, m_en}, 64'd0);
        tick();
        chk("held_reissue_c5", {63'b0, m_en}, 64'd1);
        tick(); tick();
        chk("held_ack_c7", {63'b0, d_ack}, 64'd1);
        d_req = 0;
        tick();

        // reset in the middle of a fetch
        i_req = 1; i_addr = 8'h04; cyc = 0;
        tick(); tick();
        rst = 1; i_req = 0;
        tick();
        chk("abort_m_en", {63'b0, m_en}, 64'd0);
        chk("abort_i_ack", {63'b0, i_ack}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_i_rdata", {32'b0, i_rdata}, 64'd0);
        rst = 0;
        tick();
        i_req = 1; cyc = 0;
        sb.push_back('{port: 1'b0, data: 32'h8C22_0000});
        tick(); tick(); tick();
        chk("after_abort_i_ack", {63'b0, i_ack}, 64'd1);
        i_req = 0;
        tick();
        chk("final_sb_drained", 64'(sb.size()), 64'd0);

        // LAT=1 build
        b_d_req = 1; b_d_addr = 8'h20;
        tick();
        chk("lat1_m_en_c1", {63'b0, b_m_en}, 64'd1);
        chk("lat1_d_ack_c1", {63'b0, b_d_ack}, 64'd0);
        b_d_req = 0;
        tick();
        chk("lat1_m_en_c2", {63'b0, b_m_en}, 64'd0);
        chk("lat1_d_ack_c2", {63'b0, b_d_ack}, 64'd1);
        chk("lat1_d_rdata", {32'b0, b_d_rdata}, 64'hCAFE_F00D);
        tick();
        chk("lat1_idle_c3", {63'b0, b_busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
